// File: rtl/demux_reg1to2.sv
// One-to-two demultiplexer with a single registered buffer per output channel.
// Each channel counts the words it delivers (8-bit, wrapping).
module demux_reg1to2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  // Handshake: a word moves across a port at a rising edge exactly when that
  // port's valid and ready are both 1 in the cycle before the edge.

  logic             full0, full1;
  logic [WIDTH-1:0] data0, data1;
  logic             tx0, tx1;
  logic             rx0, rx1;
  logic             sel_free;

  assign tx0 = full0 && out0_ready;
  assign tx1 = full1 && out1_ready;

  // Only the selected channel decides acceptance; the other channel is never looked at.
  assign sel_free = in_sel ? (!full1 || out1_ready) : (!full0 || out0_ready);
  assign in_ready = rst_n && !flush && sel_free;

  assign rx0 = in_valid && in_ready && !in_sel;
  assign rx1 = in_valid && in_ready &&  in_sel;

  assign out0_valid = full0;
  assign out1_valid = full1;
  assign out0_data  = data0;
  assign out1_data  = data1;

  // A new word loaded while the old one leaves keeps the buffer full (no bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full0 <= 1'b0;
      data0 <= '0;
    end else if (flush) begin
      full0 <= 1'b0;
    end else if (rx0) begin
      full0 <= 1'b1;
      data0 <= in_data;
    end else if (tx0) begin
      full0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full1 <= 1'b0;
      data1 <= '0;
    end else if (flush) begin
      full1 <= 1'b0;
    end else if (rx1) begin
      full1 <= 1'b1;
      data1 <= in_data;
    end else if (tx1) begin
      full1 <= 1'b0;
    end
  end

  // Delivery counters still count a word consumed during a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (tx0) cnt0 <= cnt0 + 8'd1;
      if (tx1) cnt1 <= cnt1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_reg1to2.sv
// Directed bench for demux_reg1to2: reset, latency, streaming, simultaneous
// transfers, flush, counter wrap and asynchronous reset.
module tb_demux_reg1to2;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [7:0]       cnt0, cnt1;

  int tests;
  int failed;

  demux_reg1to2 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic send(input logic sel, input logic [WIDTH-1:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    in_valid = 1'b1;
    #1;
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    check("rst_out0_data", out0_data, 0);
    check("rst_out1_data", out1_data, 0);
    check("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;

    // single word to channel 0, held because out0_ready=0
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
    #1;
    check("first_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("first_out0_valid", out0_valid, 1);
    check("first_out0_data", out0_data, 32'hDEADBEEF);
    check("first_out1_valid", out1_valid, 0);
    in_sel = 1'b0; #1;
    check("blocked_ready_sel0", in_ready, 0);
    in_sel = 1'b1; #1;
    check("free_ready_sel1", in_ready, 1);
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    check("drain_out0_valid", out0_valid, 0);
    check("drain_cnt0", cnt0, 1);

    // streaming ten words on channel 1
    do_reset();
    out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h100 + i;
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_out1_valid", out1_valid, 1);
      check("stream_out1_data", out1_data, 32'h100 + i);
      check("stream_out0_valid", out0_valid, 0);
    end
    in_valid = 1'b0;
    tick();
    out1_ready = 1'b0;
    check("stream_end_valid", out1_valid, 0);
    check("stream_cnt1", cnt1, 10);
    check("stream_cnt0", cnt0, 0);

    // both full, both consumed, new word replaces channel 0
    do_reset();
    send(1'b0, 32'h11);
    send(1'b1, 32'h22);
    check("both_out0_data", out0_data, 32'h11);
    check("both_out1_data", out1_data, 32'h22);
    check("both_out1_valid", out1_valid, 1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h33;
    #1;
    check("both_in_ready", in_ready, 1);
    tick();
    idle_inputs();
    check("both_out0_valid", out0_valid, 1);
    check("both_out0_new", out0_data, 32'h33);
    check("both_out1_empty", out1_valid, 0);
    check("both_cnt0", cnt0, 1);
    check("both_cnt1", cnt1, 1);

    // flush with both channels full and a word offered
    send(1'b1, 32'h44);
    check("pre_flush_out1", out1_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55;
    #1;
    check("flush_ready_sel0", in_ready, 0);
    in_sel = 1'b1; #1;
    check("flush_ready_sel1", in_ready, 0);
    tick();
    idle_inputs();
    check("flush_out0_valid", out0_valid, 0);
    check("flush_out1_valid", out1_valid, 0);
    check("flush_cnt0", cnt0, 1);
    check("flush_cnt1", cnt1, 1);
    tick();
    check("flush_no_ghost0", out0_valid, 0);
    check("flush_no_ghost1", out1_valid, 0);
    // consumer takes the word in the flush cycle: still counted
    send(1'b0, 32'h66);
    flush = 1'b1; out0_ready = 1'b1;
    tick();
    idle_inputs();
    check("flush_tx_cnt0", cnt0, 2);
    check("flush_tx_valid", out0_valid, 0);

    // counter wrap on channel 0
    do_reset();
    out0_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = i;
      tick();
      check("wrap_out0_data", out0_data, i);
    end
    in_valid = 1'b0;
    tick();
    check("wrap_cnt0_zero", cnt0, 0);
    check("wrap_out0_empty", out0_valid, 0);
    send(1'b0, 32'hABCD);
    tick();
    check("wrap_cnt0_one", cnt0, 1);
    check("wrap_cnt1", cnt1, 0);
    out0_ready = 1'b0;

    // asynchronous reset while channel 1 is full
    send(1'b1, 32'h77);
    check("areset_pre_valid", out1_valid, 1);
    in_valid = 1'b1; in_sel = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_out1_valid", out1_valid, 0);
    check("areset_out1_data", out1_data, 0);
    check("areset_cnt0", cnt0, 0);
    check("areset_in_ready", in_ready, 0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    out1_ready = 1'b1;
    tick();
    tick();
    check("areset_no_ghost1", out1_valid, 0);
    check("areset_no_ghost0", out0_valid, 0);
    check("areset_cnt1", cnt1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/demux_reg1to2.md
DEMUX_REG1TO2 -- requirements
Module: demux_reg1to2

Interface
REQ-001 Parameter: WIDTH, default 32, data width of input and both output channels.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous clear of both output buffers.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts input word this cycle.
REQ-007 in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1; sampled with in_data.
REQ-008 in_data  input  WIDTH  input word.
REQ-009 out0_valid / out1_valid  output  1 each  channel buffer holds a word.
REQ-010 out0_ready / out1_ready  input  1 each  consumer takes word this cycle.
REQ-011 out0_data / out1_data  output  WIDTH each  channel buffer contents.
REQ-012 cnt0 / cnt1  output  8 each  count of words delivered on channel 0 / channel 1.

Function
REQ-013 Each channel SHALL hold a one-entry register buffer: full flag plus WIDTH data register; outN_valid SHALL equal the full flag; outN_data SHALL be driven directly from the data register.
REQ-014 Input transfer SHALL occur when in_valid && in_ready at a rising edge; output transfer on channel N SHALL occur when outN_valid && outN_ready.
REQ-015 in_ready SHALL be combinational: in_ready = !flush && (!full[in_sel] || outN_ready for N = in_sel); it SHALL NOT depend on the non-selected channel.
REQ-016 Latency SHALL be one cycle: a word accepted at edge k SHALL appear on outN_valid/outN_data after edge k.
REQ-017 Simultaneous output transfer and input transfer on the same full channel SHALL replace the buffer with the new word, full remains 1, no bubble, giving one word per cycle per channel.
REQ-018 Output transfer without input transfer to that channel SHALL clear its full flag.
REQ-019 Input transfer to one channel SHALL NOT alter the other channel's buffer, flag or data.
REQ-020 Both channels MAY transfer out in the same cycle; no ordering between channels SHALL be enforced.
REQ-021 Data register of a channel SHALL hold its value while full and not being replaced; data contents when empty SHALL be don't-care for checkers.
REQ-022 cntN SHALL increment by 1 on each channel-N output transfer and wrap 255 -> 0.
REQ-023 flush=1 SHALL clear both full flags at the next edge, force in_ready=0 during that cycle, and discard any word offered; counters SHALL be unaffected by flush, and an output transfer occurring in the flush cycle SHALL still be counted.
REQ-024 in_sel and in_data SHALL be ignored when in_valid=0; in_ready behaviour in that cycle SHALL still follow REQ-015.
REQ-025 The block SHALL NOT drop or duplicate a word: every accepted, unflushed word SHALL be delivered exactly once on its selected channel.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force out0_valid=0, out1_valid=0, cnt0=0, cnt1=0, and out0_data=out1_data=0.
REQ-027 Reset asserted mid-transfer SHALL discard buffered words; after rst_n rises the first edge SHALL behave as from empty.
REQ-028 While rst_n=0, in_ready SHALL be 0.

Verification
REQ-029 Reset, then in_valid=1, sel=0, data=0xDEADBEEF, out0_ready=0 -> out0_valid=1, out0_data=0xDEADBEEF next cycle; in_ready for sel=0 is 0 while out0_ready=0 and 1 for sel=1.
REQ-030 Streaming: 10 words on sel=1 back-to-back, out1_ready=1 -> 10 consecutive out1_valid cycles in order, cnt1=10, cnt0=0, out0_valid never 1.
REQ-031 Both channels full with 0x11 and 0x22, both readies=1 in the same cycle with a new sel=0 word 0x33 -> next cycle out0=0x33 valid, out1_valid=0, cnt0=1, cnt1=1.
REQ-032 Both channels full, flush=1 for one cycle with in_valid=1 -> in_ready=0, both valids 0 next cycle, counters unchanged, offered word never appears.
REQ-033 Deliver 256 words on channel 0 -> cnt0 wraps to 0; one more -> cnt0=1.
REQ-034 rst_n pulsed low between edges while channel 1 full -> out1_valid drops to 0 asynchronously, counters 0, no ghost delivery after release.
